// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: writeback select codes, load funct3 codes and FSM states
package wb_stage_pkg;
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_LOAD_WAIT = 2'd2
  } wb_state_e;
endpackage

// File: rtl/load_extend.sv
// load_extend: aligns and extends a raw load word by funct3 and byte offset
module load_extend
  import wb_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] rdata,
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  output logic [DWIDTH-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // halfwords use off[1] only, so misaligned halfwords silently round down
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    data = funct3 == FNC_LB  ? {{(DWIDTH-8){b[7]}}, b} :
           funct3 == FNC_LBU ? {{(DWIDTH-8){1'b0}}, b} :
           funct3 == FNC_LH  ? {{(DWIDTH-16){h[15]}}, h} :
           funct3 == FNC_LHU ? {{(DWIDTH-16){1'b0}}, h} : rdata;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback register, load alignment and load-wait stall FSM
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [RWIDTH-1:0] ex_rd,
  input  logic              ex_reg_we,
  input  logic [1:0]        ex_wb_sel,
  input  logic [DWIDTH-1:0] ex_alu_result,
  input  logic [DWIDTH-1:0] ex_pc_plus4,
  input  logic [2:0]        ex_funct3,
  input  logic              flush,
  input  logic [DWIDTH-1:0] dmem_rdata,
  input  logic              dmem_rvalid,
  output logic [RWIDTH-1:0] wb_addr,
  output logic [DWIDTH-1:0] wb_data,
  output logic              is_wb,
  output logic              wb_stall
);
  wb_state_e         state_q;
  logic [RWIDTH-1:0] rd_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [DWIDTH-1:0] data_q, data_d, ld_data;
  logic              waiting;
  load_extend #(.DWIDTH(DWIDTH)) u_ext (
    .rdata (dmem_rdata),
    .funct3(f3_q),
    .off   (off_q),
    .data  (ld_data)
  );
  // a waiting load bypasses the register so forwarding sees it the cycle it arrives
  always_comb begin
    waiting  = state_q == ST_LOAD_WAIT;
    wb_stall = waiting & ~dmem_rvalid;
    wb_data  = waiting & dmem_rvalid ? ld_data : data_q;
    wb_addr  = rd_q;
    is_wb    = (state_q != ST_IDLE) & we_q & (|rd_q) & (~waiting | dmem_rvalid);
    data_d   = ex_valid & ~flush & (ex_wb_sel != WB_SEL_MEM) ?
               (ex_wb_sel == WB_SEL_PC4 ? ex_pc_plus4 : ex_alu_result) : wb_data;
  end
  // capture the next EX instruction whenever not stalled; bubbles keep the last shown value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      data_q  <= '0;
    end else if (!wb_stall) begin
      data_q <= data_d;
      if (!ex_valid || flush) begin
        state_q <= ST_IDLE;
        we_q    <= 1'b0;
      end else begin
        rd_q    <= ex_rd;
        we_q    <= ex_reg_we;
        f3_q    <= ex_funct3;
        off_q   <= ex_alu_result[1:0];
        state_q <= ex_wb_sel == WB_SEL_MEM ? ST_LOAD_WAIT : ST_ACTIVE;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a behavioural model
module tb_wb_stage;
  logic        clk = 0, rst_n = 0;
  logic        ex_valid = 0, ex_reg_we = 0, flush = 0, dmem_rvalid = 0;
  logic [4:0]  ex_rd = 0;
  logic [1:0]  ex_wb_sel = 0;
  logic [31:0] ex_alu_result = 0, ex_pc_plus4 = 0, dmem_rdata = 0;
  logic [2:0]  ex_funct3 = 0;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        is_wb, wb_stall;
  int n_tests = 0, n_fail = 0;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_wb_sel(ex_wb_sel), .ex_alu_result(ex_alu_result), .ex_pc_plus4(ex_pc_plus4),
    .ex_funct3(ex_funct3), .flush(flush), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .wb_addr(wb_addr), .wb_data(wb_data), .is_wb(is_wb), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  // model: the instruction currently held and the last value shown on wb_data
  bit          m_busy, m_load, m_we;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [31:0] m_last;

  function automatic logic [31:0] align(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return b >= 128 ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return h >= 32768 ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit m_stall();
    return m_busy && m_load && !dmem_rvalid;
  endfunction

  function automatic bit m_wb();
    return m_busy && m_we && m_rd != 0 && (!m_load || dmem_rvalid);
  endfunction

  function automatic logic [31:0] m_data();
    return (m_busy && m_load && dmem_rvalid) ? align(dmem_rdata, m_f3, m_off) : m_last;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_load = 0; m_we = 0; m_rd = 0; m_f3 = 0; m_off = 0; m_last = 0;
  endtask

  task automatic ex(input bit v, input logic [4:0] rd, input bit we, input logic [1:0] sel,
                    input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3, input bit fl);
    ex_valid = v; ex_rd = rd; ex_reg_we = we; ex_wb_sel = sel;
    ex_alu_result = alu; ex_pc_plus4 = pc4; ex_funct3 = f3; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!m_stall()) begin
      if (m_busy && m_load) m_last = align(dmem_rdata, m_f3, m_off);
      if (!ex_valid || flush) begin
        m_busy = 0; m_we = 0;
      end else begin
        m_busy = 1; m_rd = ex_rd; m_we = ex_reg_we; m_load = ex_wb_sel == 2'd1;
        m_f3 = ex_funct3; m_off = ex_alu_result[1:0];
        if (!m_load) m_last = ex_wb_sel == 2'd2 ? ex_pc_plus4 : ex_alu_result;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #23;
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset: addr=%0d data=%h wb=%b stall=%b, want all 0", wb_addr, wb_data, is_wb, wb_stall);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_alu();
    ex(1, 5'd5, 1, 2'd0, 32'h10, 32'h0, 3'd0, 0);
    dmem_rvalid = $urandom_range(0, 1);
    tick();
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== {5'd5, 32'h10, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL alu: addr=%0d data=%h wb=%b stall=%b, want 5 00000010 1 0", wb_addr, wb_data, is_wb, wb_stall);
    end
    dmem_rvalid = 0;
    tick();
  endtask

  task automatic test_lb_fast();
    ex(1, 5'd7, 1, 2'd1, 32'h1003, 32'h0, 3'd0, 0);
    tick();
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_rvalid = 1; dmem_rdata = 32'h8012_3456;
    @(negedge clk);
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== {5'd7, 32'hFFFF_FF80, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL lb_fast: addr=%0d data=%h wb=%b stall=%b, want 7 ffffff80 1 0", wb_addr, wb_data, is_wb, wb_stall);
    end
    tick();
    dmem_rvalid = 0;
    @(negedge clk);
    n_tests++;
    if ({is_wb, wb_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL lb_after: wb=%b stall=%b, want 0 0", is_wb, wb_stall);
    end
    tick();
  endtask

  task automatic test_lhu_slow();
    ex(1, 5'd9, 1, 2'd1, 32'h2, 32'h0, 3'd5, 0);
    tick();
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_rdata = 32'hBEEF_1234;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({is_wb, wb_stall} !== 2'b01) begin
        n_fail++;
        $display("FAIL lhu_stall%0d: wb=%b stall=%b, want 0 1", i, is_wb, wb_stall);
      end
      tick();
    end
    dmem_rvalid = 1;
    @(negedge clk);
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== {5'd9, 32'h0000_BEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL lhu_data: addr=%0d data=%h wb=%b stall=%b, want 9 0000beef 1 0", wb_addr, wb_data, is_wb, wb_stall);
    end
    tick();
    dmem_rvalid = 0;
    @(negedge clk);
    n_tests++;
    if ({is_wb, wb_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL lhu_after: wb=%b stall=%b, want 0 0", is_wb, wb_stall);
    end
    tick();
  endtask

  task automatic test_x0_flush();
    ex(1, 5'd0, 1, 2'd0, 32'hDEAD, 32'h0, 3'd0, 0);
    tick();
    ex(1, 5'd3, 1, 2'd0, 32'hBEEF, 32'h0, 3'd0, 1);
    @(negedge clk);
    n_tests++;
    if (is_wb !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write: wb=%b, want 0", is_wb);
    end
    tick();
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (is_wb !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: wb=%b, want 0", is_wb);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    ex(1, 5'd4, 1, 2'd1, 32'h40, 32'h0, 3'd2, 0);
    tick();
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_rvalid = 0;
    @(negedge clk);
    n_tests++;
    if (wb_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_stall: stall=%b, want 1", wb_stall);
    end
    #1 rst_n = 0;
    model_reset();
    #1;
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== 39'd0) begin
      n_fail++;
      $display("FAIL rst_mid: addr=%0d data=%h wb=%b stall=%b, want all 0", wb_addr, wb_data, is_wb, wb_stall);
    end
    @(negedge clk);
    rst_n = 1;
    dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
    #1;
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== 39'd0) begin
      n_fail++;
      $display("FAIL rst_late_rvalid: addr=%0d data=%h wb=%b stall=%b, want all 0", wb_addr, wb_data, is_wb, wb_stall);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({is_wb, wb_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_idle: wb=%b stall=%b, want 0 0", is_wb, wb_stall);
    end
    dmem_rvalid = 0;
    tick();
  endtask

  task automatic test_jal_lw();
    logic [31:0] w;
    w = $urandom;
    ex(1, 5'd1, 1, 2'd2, 32'h0, 32'h0000_1004, 3'd0, 0);
    tick();
    ex(1, 5'd2, 1, 2'd1, 32'h100, 32'h0, 3'd2, 0);
    @(negedge clk);
    n_tests++;
    if ({wb_addr, wb_data, is_wb} !== {5'd1, 32'h1004, 1'b1}) begin
      n_fail++;
      $display("FAIL jal: addr=%0d data=%h wb=%b, want 1 00001004 1", wb_addr, wb_data, is_wb);
    end
    tick();
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_rvalid = 1; dmem_rdata = w;
    @(negedge clk);
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== {5'd2, w, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL jal_lw: addr=%0d data=%h wb=%b stall=%b, want 2 %h 1 0", wb_addr, wb_data, is_wb, wb_stall, w);
    end
    tick();
    dmem_rvalid = 0;
  endtask

  task automatic test_back_to_back();
    ex(1, 5'd6, 1, 2'd1, 32'h1, 32'h0, 3'd4, 0);
    tick();
    ex(1, 5'd8, 1, 2'd1, 32'h2, 32'h0, 3'd1, 0);
    dmem_rvalid = 1; dmem_rdata = 32'h0000_9A00;
    @(negedge clk);
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== {5'd6, 32'h9A, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first: addr=%0d data=%h wb=%b stall=%b, want 6 0000009a 1 0", wb_addr, wb_data, is_wb, wb_stall);
    end
    tick();
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_rdata = 32'h8001_0000;
    @(negedge clk);
    n_tests++;
    if ({wb_addr, wb_data, is_wb, wb_stall} !== {5'd8, 32'hFFFF_8001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: addr=%0d data=%h wb=%b stall=%b, want 8 ffff8001 1 0", wb_addr, wb_data, is_wb, wb_stall);
    end
    tick();
    dmem_rvalid = 0;
  endtask

  task automatic test_random();
    bit ew;
    for (int i = 0; i < 600; i++) begin
      ex($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
         2'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom), $urandom_range(0, 7) == 0);
      dmem_rvalid = $urandom_range(0, 4) < 2;
      dmem_rdata = $urandom;
      @(negedge clk);
      ew = m_wb();
      n_tests++;
      if ({is_wb, wb_stall} !== {ew, m_stall()}) begin
        n_fail++;
        $display("FAIL rand%0d_ctl: wb=%b stall=%b, want %b %b", i, is_wb, wb_stall, ew, m_stall());
      end
      if (ew) begin
        n_tests++;
        if (wb_addr !== m_rd) begin
          n_fail++;
          $display("FAIL rand%0d_addr: addr=%0d, want %0d", i, wb_addr, m_rd);
        end
      end
      if (!m_stall()) begin
        n_tests++;
        if (wb_data !== m_data()) begin
          n_fail++;
          $display("FAIL rand%0d_data: data=%h, want %h", i, wb_data, m_data());
        end
      end
      tick();
    end
    ex(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_fast();
    test_lhu_slow();
    test_x0_flush();
    test_reset_mid_load();
    test_jal_lw();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
